// File: rtl/uart_tx_sr.sv
// -----------------------------------------------------------------------------
// uart_tx_sr
//   Transmit half of the UART link. Serialises one packet per frame as
//   start bit (0), NUM_DATA_BITS data bits LSB first, and one stop bit (1).
//   The frame layout matches the receive path's 9-bit capture (data + stop).
//   Inside: a bit-period timer, a data-bit counter, the frame FSM and a
//   load/shift register. Every output comes straight from a register.
//
// Parameters
//   CLKS_PER_BIT   clk cycles per serial bit (>= 2)
//   NUM_DATA_BITS  data bits per frame (LSB first)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active-high, wins over tx_start
//   tx_start    in   send request; taken only while idle (tx_busy = 0)
//   tx_data     in   packet, sampled on the accept edge only
//   serial_out  out  serial line, idles high
//   tx_busy     out  high from the cycle after accept through the last stop cycle
//   tx_done     out  one-cycle pulse in the first idle cycle after the stop bit
// -----------------------------------------------------------------------------
module uart_tx_sr #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam int TW = (CLKS_PER_BIT  > 1) ? $clog2(CLKS_PER_BIT)  : 1;
    localparam int BW = (NUM_DATA_BITS > 1) ? $clog2(NUM_DATA_BITS) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_DATA_BITS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]               state_q,   state_d;
    logic [TW-1:0]            timer_q,   timer_d;
    logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [NUM_DATA_BITS-1:0] shift_q,   shift_d;
    logic                     serial_q,  serial_d;
    logic                     busy_q,    busy_d;
    logic                     done_q,    done_d;

    // The last cycle of the current bit period; the only point where a bit
    // or a state may advance.
    logic wrap;
    assign wrap = (timer_q == TIMER_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default before the case, so no
        // path leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        serial_d  = serial_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Timer sits at 0 while idle, so the first START cycle begins a
        // full bit period.
        if (state_q == S_IDLE || wrap) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                busy_d   = 1'b0;
                if (tx_start) begin
                    state_d   = S_START;
                    shift_d   = tx_data;
                    bit_cnt_d = '0;
                    serial_d  = 1'b0;
                    busy_d    = 1'b1;
                end
            end

            S_START: begin
                if (wrap) begin
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end
            end

            S_DATA: begin
                if (wrap) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d  = S_STOP;
                        serial_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        // Shift right with 1 fill; the line takes the bit
                        // that lands in position 0.
                        shift_d   = {1'b1, shift_q[NUM_DATA_BITS-1:1]};
                        serial_d  = shift_q[1];
                    end
                end
            end

            S_STOP: begin
                if (wrap) begin
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end

            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is a handful of flops, not a memory,
            // so clearing it on reset costs nothing and keeps it defined.
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign serial_out = serial_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_sr.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sr
//   Self-checking bench for uart_tx_sr. Two instances share clock and reset:
//   dut_a with the default 10 clocks per bit, dut_b with 2 clocks per bit.
//   'sel' routes the request to one of them and picks whose outputs are
//   observed. Inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_sr;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sel;
    logic [7:0] data;

    logic so_a, busy_a, done_a;
    logic so_b, busy_b, done_b;
    logic so, busy, done;

    always #5 clk = ~clk;

    uart_tx_sr #(.CLKS_PER_BIT(10), .NUM_DATA_BITS(8)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (start & ~sel),
        .tx_data    (data),
        .serial_out (so_a),
        .tx_busy    (busy_a),
        .tx_done    (done_a)
    );

    uart_tx_sr #(.CLKS_PER_BIT(2), .NUM_DATA_BITS(8)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (start & sel),
        .tx_data    (data),
        .serial_out (so_b),
        .tx_busy    (busy_b),
        .tx_done    (done_b)
    );

    assign so   = sel ? so_b   : so_a;
    assign busy = sel ? busy_b : busy_a;
    assign done = sel ? done_b : done_a;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference line level k cycles after the accept edge (k = 1 is the first
    // START cycle): bit slot (k-1)/c picks start, data[slot-1] or stop/idle.
    function automatic logic model_serial(input logic [7:0] d, input int k, input int c);
        int slot;
        if (k > 10 * c) return 1'b1;
        slot = (k - 1) / c;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        return 1'b1;
    endfunction

    // Caller has already driven start=1 / data=d for the coming (accept) edge.
    // Records the whole frame plus the tx_done cycle and compares it to the
    // model. Returns at the falling edge inside the tx_done cycle with start=0,
    // so the caller can still raise start to chain the next frame.
    task automatic check_frame(input logic [7:0] d, input string tag, input bit noise,
                               input int poke_at, input logic [7:0] poke_data);
        int c = sel ? 2 : 10;
        int f = 10 * c;
        logic [127:0] obs_s = '0, obs_b = '0, obs_d = '0;
        logic [127:0] exp_s = '0, exp_b = '0, exp_d = '0;
        logic [7:0]   rx;
        logic         rx_stop;
        for (int k = 1; k <= f + 1; k++) begin
            @(negedge clk);
            obs_s[k] = so;
            obs_b[k] = busy;
            obs_d[k] = done;
            exp_s[k] = model_serial(d, k, c);
            exp_b[k] = (k <= f);
            exp_d[k] = (k == f + 1);
            start = 1'b0;
            if (k <= f) begin
                data = 8'($urandom);
                if (noise && $urandom_range(0, 5) == 0) start = 1'b1;
                if (k == poke_at) begin
                    start = 1'b1;
                    data  = poke_data;
                end
            end
        end
        check({tag, "_serial"}, obs_s, exp_s);
        check({tag, "_busy"},   obs_b, exp_b);
        check({tag, "_done"},   obs_d, exp_d);
        // Mid-bit sampling as the receive path would do it.
        for (int i = 0; i < 8; i++) rx[i] = obs_s[(i + 1) * c + c / 2 + 1];
        rx_stop = obs_s[9 * c + c / 2 + 1];
        check({tag, "_rx_data"}, 128'(rx), 128'(d));
        check({tag, "_rx_stop"}, 128'(rx_stop), 128'(1'b1));
    endtask

    task automatic check_idle(input int n, input string tag);
        int bad = 0;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if ({so, busy, done} !== 3'b100) bad++;
        end
        check(tag, 128'(bad), 128'(0));
    endtask

    typedef struct {
        logic       rst;
        logic       start;
        logic [7:0] data;
        logic       exp_ser;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [7:0] d;

        // Reset with a request held high, release, then a frame aborted by
        // reset right after it starts.
        vecs[0] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b1;
        data  = 8'hA5;
        sel   = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            rst   = vecs[i].rst;
            start = vecs[i].start;
            data  = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d", i), 128'({so, busy, done}),
                  128'({vecs[i].exp_ser, vecs[i].exp_busy, vecs[i].exp_done}));
        end
        start = 1'b0;

        // Single frame of 8'hA5.
        start = 1'b1; data = 8'hA5;
        check_frame(8'hA5, "a5", 1'b0, -1, 8'h00);
        check_idle(3, "a5_idle");

        // Back-to-back: request in the tx_done cycle chains the next frame.
        start = 1'b1; data = 8'h00;
        check_frame(8'h00, "b2b_first", 1'b0, -1, 8'h00);
        start = 1'b1; data = 8'hFF;
        check_frame(8'hFF, "b2b_second", 1'b0, -1, 8'h00);
        check_idle(5, "b2b_idle");

        // Request during a frame is dropped, nothing queued.
        start = 1'b1; data = 8'h81;
        check_frame(8'h81, "ign", 1'b0, 40, 8'h3C);
        check_idle(30, "ign_no_second");

        // Reset in data bit 3 of 8'h55 (cycles 41..50 after accept).
        start = 1'b1; data = 8'h55;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            start = 1'b0;
            data  = 8'($urandom);
        end
        check("mid_bit3", 128'({so, busy}), 128'(2'b01));
        rst = 1'b1;
        @(negedge clk);
        check("mid_abort", 128'({so, busy, done}), 128'(3'b100));
        rst = 1'b0;
        check_idle(120, "mid_no_done");
        start = 1'b1; data = 8'h55;
        check_frame(8'h55, "after_rst", 1'b0, -1, 8'h00);
        check_idle(2, "after_rst_idle");

        // Random frames with stray requests and data changes mid-frame,
        // random gaps (0 = chained in the tx_done cycle).
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            start = 1'b1; data = d;
            check_frame(d, $sformatf("rnd%0d", i), 1'b1, -1, 8'h00);
            if ($urandom_range(0, 2) != 0) check_idle($urandom_range(1, 4), "rnd_gap");
        end
        check_idle(3, "rnd_end_idle");

        // Two clocks per bit.
        sel = 1'b1;
        check_idle(2, "c2_idle");
        start = 1'b1; data = 8'h01;
        check_frame(8'h01, "c2_01", 1'b0, -1, 8'h00);
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            start = 1'b1; data = d;
            check_frame(d, $sformatf("c2_rnd%0d", i), 1'b1, -1, 8'h00);
        end
        check_idle(4, "c2_end_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
